// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: opcode values, legality check and
// sequencer state encoding.
package alu_pkg;

   localparam logic [3:0] OP_AND = 4'b0000;
   localparam logic [3:0] OP_OR  = 4'b0001;
   localparam logic [3:0] OP_ADD = 4'b0010;
   localparam logic [3:0] OP_SUB = 4'b0110;
   localparam logic [3:0] OP_SLT = 4'b0111;
   localparam logic [3:0] OP_XOR = 4'b1000;
   localparam logic [3:0] OP_NOR = 4'b1100;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_e;

   function automatic logic op_legal(input logic [3:0] op);
      case (op)
         OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_XOR, OP_NOR: op_legal = 1'b1;
         default:                                               op_legal = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/alu.sv
// Shared combinational 32-bit ALU; illegal opcodes produce zero.
module alu
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] oprd1,
   input  logic [WIDTH-1:0] oprd2,
   input  logic [3:0]       ALU_Operation,
   output logic [WIDTH-1:0] ALU_result,
   output logic             zero
);

   logic slt_bit;

   assign slt_bit = ($signed(oprd1) < $signed(oprd2));

   always_comb begin
      ALU_result = '0;
      case (ALU_Operation)
         OP_AND:  ALU_result = oprd1 & oprd2;
         OP_OR:   ALU_result = oprd1 | oprd2;
         OP_ADD:  ALU_result = oprd1 + oprd2;
         OP_SUB:  ALU_result = oprd1 - oprd2;
         OP_SLT:  ALU_result = {{(WIDTH-1){1'b0}}, slt_bit};
         OP_XOR:  ALU_result = oprd1 ^ oprd2;
         OP_NOR:  ALU_result = ~(oprd1 | oprd2);
         default: ALU_result = '0;
      endcase
   end

   assign zero = (ALU_result == '0);

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter/sequencer sharing one ALU between two requesters:
// grant in IDLE, compute from latched operands in EXEC, hold response in RESP.
module alu_arbiter
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [3:0]       req0_op,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [3:0]       req1_op,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_id,
   output logic [WIDTH-1:0] rsp_result,
   output logic             rsp_zero,
   output logic             rsp_err
);

   state_e           state_q, state_d;
   logic             prio_q, prio_d;
   logic             id_q, id_d;
   logic [3:0]       op_q, op_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic             rsp_id_q, rsp_id_d;
   logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
   logic             rsp_zero_q, rsp_zero_d;
   logic             rsp_err_q, rsp_err_d;

   logic             grant;
   logic [WIDTH-1:0] alu_result;
   logic             alu_zero;

   alu #(.WIDTH(WIDTH)) u_alu (
      .oprd1         (a_q),
      .oprd2         (b_q),
      .ALU_Operation (op_q),
      .ALU_result    (alu_result),
      .zero          (alu_zero)
   );

   always_comb begin
      state_d      = state_q;
      prio_d       = prio_q;
      id_d         = id_q;
      op_d         = op_q;
      a_d          = a_q;
      b_d          = b_q;
      rsp_id_d     = rsp_id_q;
      rsp_result_d = rsp_result_q;
      rsp_zero_d   = rsp_zero_q;
      rsp_err_d    = rsp_err_q;
      req0_ready   = 1'b0;
      req1_ready   = 1'b0;
      grant        = (req0_valid && req1_valid) ? prio_q : req1_valid;

      case (state_q)
         ST_IDLE: begin
            // Ready is withheld during reset so nothing looks accepted that gets dropped.
            if (!rst && (req0_valid || req1_valid)) begin
               req0_ready = ~grant;
               req1_ready = grant;
               id_d       = grant;
               op_d       = grant ? req1_op : req0_op;
               a_d        = grant ? req1_a  : req0_a;
               b_d        = grant ? req1_b  : req0_b;
               prio_d     = ~grant;
               state_d    = ST_EXEC;
            end
         end
         ST_EXEC: begin
            rsp_id_d = id_q;
            if (op_legal(op_q)) begin
               rsp_result_d = alu_result;
               rsp_zero_d   = alu_zero;
               rsp_err_d    = 1'b0;
            end else begin
               rsp_result_d = '0;
               rsp_zero_d   = 1'b0;
               rsp_err_d    = 1'b1;
            end
            state_d = ST_RESP;
         end
         ST_RESP: begin
            if (rsp_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         prio_q       <= 1'b0;
         id_q         <= 1'b0;
         op_q         <= '0;
         a_q          <= '0;
         b_q          <= '0;
         rsp_id_q     <= 1'b0;
         rsp_result_q <= '0;
         rsp_zero_q   <= 1'b0;
         rsp_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         prio_q       <= prio_d;
         id_q         <= id_d;
         op_q         <= op_d;
         a_q          <= a_d;
         b_q          <= b_d;
         rsp_id_q     <= rsp_id_d;
         rsp_result_q <= rsp_result_d;
         rsp_zero_q   <= rsp_zero_d;
         rsp_err_q    <= rsp_err_d;
      end
   end

   assign rsp_valid  = (state_q == ST_RESP);
   assign rsp_id     = rsp_id_q;
   assign rsp_result = rsp_result_q;
   assign rsp_zero   = rsp_zero_q;
   assign rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scenario bench for alu_arbiter: expected responses are queued at grant time
// and popped when the arbiter presents them.
module tb_alu_arbiter;
   import alu_pkg::*;

   localparam int WIDTH = 32;

   typedef struct packed {
      logic             id;
      logic [WIDTH-1:0] result;
      logic             zero;
      logic             err;
   } rsp_t;

   logic             clk = 1'b0;
   logic             rst;
   logic             req0_valid, req0_ready;
   logic [3:0]       req0_op;
   logic [WIDTH-1:0] req0_a, req0_b;
   logic             req1_valid, req1_ready;
   logic [3:0]       req1_op;
   logic [WIDTH-1:0] req1_a, req1_b;
   logic             rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_err;
   logic [WIDTH-1:0] rsp_result;

   rsp_t sb[$];
   rsp_t exp_r;
   rsp_t got;
   int   tests_run    = 0;
   int   tests_failed = 0;
   bit   ok;

   assign got = {rsp_id, rsp_result, rsp_zero, rsp_err};

   always #5 clk = ~clk;

   alu_arbiter #(.WIDTH(WIDTH)) dut (
      .clk        (clk),
      .rst        (rst),
      .req0_valid (req0_valid),
      .req0_ready (req0_ready),
      .req0_op    (req0_op),
      .req0_a     (req0_a),
      .req0_b     (req0_b),
      .req1_valid (req1_valid),
      .req1_ready (req1_ready),
      .req1_op    (req1_op),
      .req1_a     (req1_a),
      .req1_b     (req1_b),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_id     (rsp_id),
      .rsp_result (rsp_result),
      .rsp_zero   (rsp_zero),
      .rsp_err    (rsp_err)
   );

   task automatic drive0(input logic v, input logic [3:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      req0_valid = v; req0_op = op; req0_a = a; req0_b = b;
   endtask

   task automatic drive1(input logic v, input logic [3:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      req1_valid = v; req1_op = op; req1_a = a; req1_b = b;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      drive0(1'b0, 4'd0, '0, '0);
      drive1(1'b0, 4'd0, '0, '0);
      rsp_ready = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   // Waits (from a falling edge) up to 20 cycles for rsp_valid.
   task automatic wait_rsp(output bit found);
      found = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (rsp_valid === 1'b1) begin
            found = 1'b1;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic take_rsp();
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
   endtask

   task automatic test_reset();
      drive0(1'b0, 4'd0, '0, '0);
      drive1(1'b0, 4'd0, '0, '0);
      rsp_ready = 1'b0;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      tests_run++;
      if (rsp_valid !== 1'b0) begin
         tests_failed++; $display("[TB] FAIL reset_rsp_valid: got %b expected 0", rsp_valid);
      end
      tests_run++;
      if (got !== rsp_t'(0)) begin
         tests_failed++; $display("[TB] FAIL reset_rsp_fields: got %h expected 0", got);
      end
      tests_run++;
      if ({req0_ready, req1_ready} !== 2'b00) begin
         tests_failed++; $display("[TB] FAIL reset_ready: got %b expected 00", {req0_ready, req1_ready});
      end
      rst = 1'b0;
   endtask

   task automatic test_single_add();
      @(negedge clk);
      drive0(1'b1, OP_ADD, 32'd15, 32'd20);
      #1;
      tests_run++;
      if (req0_ready !== 1'b1) begin
         tests_failed++; $display("[TB] FAIL add_ready: got %b expected 1", req0_ready);
      end
      sb.push_back(rsp_t'{1'b0, 32'd35, 1'b0, 1'b0});
      @(negedge clk);
      drive0(1'b0, OP_ADD, 32'd15, 32'd20);
      #1;
      tests_run++;
      if ({rsp_valid, req0_ready} !== 2'b00) begin
         tests_failed++; $display("[TB] FAIL add_exec: got valid/ready %b expected 00", {rsp_valid, req0_ready});
      end
      @(negedge clk);
      tests_run++;
      if (rsp_valid !== 1'b1) begin
         tests_failed++; $display("[TB] FAIL add_latency: got rsp_valid %b at T+2 expected 1", rsp_valid);
      end
      exp_r = sb.pop_front();
      tests_run++;
      if (got !== exp_r) begin
         tests_failed++; $display("[TB] FAIL add_rsp: got %h expected %h", got, exp_r);
      end
      take_rsp();
      tests_run++;
      if (rsp_valid !== 1'b0) begin
         tests_failed++; $display("[TB] FAIL add_release: got rsp_valid %b expected 0", rsp_valid);
      end
   endtask

   task automatic test_both_valid();
      do_reset();
      drive0(1'b1, OP_SUB, 32'd50, 32'd50);
      drive1(1'b1, OP_AND, 32'd12, 32'd10);
      #1;
      tests_run++;
      if ({req0_ready, req1_ready} !== 2'b10) begin
         tests_failed++; $display("[TB] FAIL both_first_grant: got %b expected 10", {req0_ready, req1_ready});
      end
      sb.push_back(rsp_t'{1'b0, 32'd0, 1'b1, 1'b0});
      @(negedge clk);
      drive0(1'b0, OP_SUB, 32'd50, 32'd50);
      wait_rsp(ok);
      tests_run++;
      if (!ok) begin
         tests_failed++; $display("[TB] FAIL both_sub_timeout: got no rsp_valid expected 1");
      end
      exp_r = sb.pop_front();
      tests_run++;
      if (got !== exp_r) begin
         tests_failed++; $display("[TB] FAIL both_sub_rsp: got %h expected %h", got, exp_r);
      end
      take_rsp();
      #1;
      tests_run++;
      if ({req0_ready, req1_ready} !== 2'b01) begin
         tests_failed++; $display("[TB] FAIL both_second_grant: got %b expected 01", {req0_ready, req1_ready});
      end
      sb.push_back(rsp_t'{1'b1, 32'd8, 1'b0, 1'b0});
      @(negedge clk);
      drive0(1'b1, OP_SUB, 32'd50, 32'd50);
      wait_rsp(ok);
      tests_run++;
      if (!ok) begin
         tests_failed++; $display("[TB] FAIL both_and_timeout: got no rsp_valid expected 1");
      end
      exp_r = sb.pop_front();
      tests_run++;
      if (got !== exp_r) begin
         tests_failed++; $display("[TB] FAIL both_and_rsp: got %h expected %h", got, exp_r);
      end
      take_rsp();
      #1;
      tests_run++;
      if ({req0_ready, req1_ready} !== 2'b10) begin
         tests_failed++; $display("[TB] FAIL both_alternate: got %b expected 10", {req0_ready, req1_ready});
      end
      sb.push_back(rsp_t'{1'b0, 32'd0, 1'b1, 1'b0});
      @(negedge clk);
      drive0(1'b0, OP_SUB, 32'd50, 32'd50);
      drive1(1'b0, OP_AND, 32'd12, 32'd10);
      wait_rsp(ok);
      exp_r = sb.pop_front();
      tests_run++;
      if (!ok || got !== exp_r) begin
         tests_failed++; $display("[TB] FAIL both_third_rsp: got valid %b rsp %h expected %h", ok, got, exp_r);
      end
      take_rsp();
   endtask

   task automatic test_backpressure();
      do_reset();
      drive0(1'b1, OP_SLT, -32'sd5, 32'd10);
      drive1(1'b1, OP_OR, 32'd3, 32'd4);
      #1;
      tests_run++;
      if ({req0_ready, req1_ready} !== 2'b10) begin
         tests_failed++; $display("[TB] FAIL bp_grant: got %b expected 10", {req0_ready, req1_ready});
      end
      sb.push_back(rsp_t'{1'b0, 32'd1, 1'b0, 1'b0});
      @(negedge clk);
      drive0(1'b0, OP_SLT, -32'sd5, 32'd10);
      wait_rsp(ok);
      tests_run++;
      if (!ok) begin
         tests_failed++; $display("[TB] FAIL bp_timeout: got no rsp_valid expected 1");
      end
      for (int i = 0; i < 5; i++) begin
         tests_run++;
         if ({rsp_valid, got, req1_ready} !== {1'b1, sb[0], 1'b0}) begin
            tests_failed++;
            $display("[TB] FAIL bp_hold%0d: got valid %b rsp %h ready1 %b expected 1 %h 0", i, rsp_valid, got, req1_ready, sb[0]);
         end
         @(negedge clk);
      end
      exp_r = sb.pop_front();
      tests_run++;
      if (got !== exp_r) begin
         tests_failed++; $display("[TB] FAIL bp_rsp: got %h expected %h", got, exp_r);
      end
      rsp_ready = 1'b1;
      #1;
      tests_run++;
      if (req1_ready !== 1'b0) begin
         tests_failed++; $display("[TB] FAIL bp_ready_early: got %b expected 0", req1_ready);
      end
      @(negedge clk);
      rsp_ready = 1'b0;
      #1;
      tests_run++;
      if (req1_ready !== 1'b1) begin
         tests_failed++; $display("[TB] FAIL bp_ready_after: got %b expected 1", req1_ready);
      end
      sb.push_back(rsp_t'{1'b1, 32'd7, 1'b0, 1'b0});
      @(negedge clk);
      drive1(1'b0, OP_OR, 32'd3, 32'd4);
      wait_rsp(ok);
      exp_r = sb.pop_front();
      tests_run++;
      if (!ok || got !== exp_r) begin
         tests_failed++; $display("[TB] FAIL bp_or_rsp: got valid %b rsp %h expected %h", ok, got, exp_r);
      end
      take_rsp();
   endtask

   task automatic test_illegal();
      drive1(1'b1, 4'b0011, 32'd7, 32'd11);
      #1;
      tests_run++;
      if (req1_ready !== 1'b1) begin
         tests_failed++; $display("[TB] FAIL illegal_ready: got %b expected 1", req1_ready);
      end
      sb.push_back(rsp_t'{1'b1, 32'd0, 1'b0, 1'b1});
      @(negedge clk);
      drive1(1'b0, 4'b0011, 32'd7, 32'd11);
      wait_rsp(ok);
      exp_r = sb.pop_front();
      tests_run++;
      if (!ok || got !== exp_r) begin
         tests_failed++; $display("[TB] FAIL illegal_rsp: got valid %b rsp %h expected %h", ok, got, exp_r);
      end
      take_rsp();
   endtask

   task automatic test_reset_exec();
      bit seen;
      do_reset();
      drive0(1'b1, OP_XOR, 32'hAAAAAAAA, 32'h55555555);
      #1;
      tests_run++;
      if (req0_ready !== 1'b1) begin
         tests_failed++; $display("[TB] FAIL rstx_grant: got %b expected 1", req0_ready);
      end
      @(negedge clk);
      drive0(1'b0, OP_XOR, 32'hAAAAAAAA, 32'h55555555);
      rst = 1'b1;
      @(negedge clk);
      #1;
      tests_run++;
      if ({rsp_valid, got, req0_ready, req1_ready} !== {1'b0, rsp_t'(0), 2'b00}) begin
         tests_failed++; $display("[TB] FAIL rstx_outputs: got valid %b rsp %h ready %b%b expected all 0", rsp_valid, got, req0_ready, req1_ready);
      end
      rst = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (rsp_valid !== 1'b0) seen = 1'b1;
      end
      tests_run++;
      if (seen) begin
         tests_failed++; $display("[TB] FAIL rstx_no_rsp: got rsp_valid 1 after reset expected 0");
      end
      drive0(1'b1, OP_ADD, 32'd1, 32'd1);
      drive1(1'b1, OP_ADD, 32'd2, 32'd2);
      #1;
      tests_run++;
      if ({req0_ready, req1_ready} !== 2'b10) begin
         tests_failed++; $display("[TB] FAIL rstx_prio: got %b expected 10", {req0_ready, req1_ready});
      end
      sb.push_back(rsp_t'{1'b0, 32'd2, 1'b0, 1'b0});
      @(negedge clk);
      drive0(1'b0, OP_ADD, 32'd1, 32'd1);
      drive1(1'b0, OP_ADD, 32'd2, 32'd2);
      wait_rsp(ok);
      exp_r = sb.pop_front();
      tests_run++;
      if (!ok || got !== exp_r) begin
         tests_failed++; $display("[TB] FAIL rstx_rsp: got valid %b rsp %h expected %h", ok, got, exp_r);
      end
      take_rsp();
   endtask

   task automatic test_back_to_back();
      drive1(1'b1, OP_NOR, 32'd7, 32'd11);
      #1;
      tests_run++;
      if (req1_ready !== 1'b1) begin
         tests_failed++; $display("[TB] FAIL b2b_nor_grant: got %b expected 1", req1_ready);
      end
      sb.push_back(rsp_t'{1'b1, 32'hFFFFFFF0, 1'b0, 1'b0});
      @(negedge clk);
      drive1(1'b0, OP_NOR, 32'd7, 32'd11);
      drive0(1'b1, OP_XOR, 32'd12345, 32'hFFFFFFFF);
      #1;
      tests_run++;
      if (req0_ready !== 1'b0) begin
         tests_failed++; $display("[TB] FAIL b2b_exec_ready: got %b expected 0", req0_ready);
      end
      wait_rsp(ok);
      exp_r = sb.pop_front();
      tests_run++;
      if (!ok || got !== exp_r || req0_ready !== 1'b0) begin
         tests_failed++; $display("[TB] FAIL b2b_nor_rsp: got valid %b rsp %h ready0 %b expected %h ready0 0", ok, got, req0_ready, exp_r);
      end
      take_rsp();
      #1;
      tests_run++;
      if (req0_ready !== 1'b1) begin
         tests_failed++; $display("[TB] FAIL b2b_xor_grant: got %b expected 1", req0_ready);
      end
      sb.push_back(rsp_t'{1'b0, -32'sd12346, 1'b0, 1'b0});
      @(negedge clk);
      drive0(1'b0, OP_XOR, 32'd12345, 32'hFFFFFFFF);
      wait_rsp(ok);
      exp_r = sb.pop_front();
      tests_run++;
      if (!ok || got !== exp_r) begin
         tests_failed++; $display("[TB] FAIL b2b_xor_rsp: got valid %b rsp %h expected %h", ok, got, exp_r);
      end
      take_rsp();
   endtask

   initial begin
      rst = 1'b1;
      rsp_ready = 1'b0;
      drive0(1'b0, 4'd0, '0, '0);
      drive1(1'b0, 4'd0, '0, '0);
      test_reset();
      test_single_add();
      test_both_valid();
      test_backpressure();
      test_illegal();
      test_reset_exec();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got no completion by 200000 expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
